// File: rtl/prog_mem_if.sv
// Fetch and loader bus between the CPU/loader and the writable program memory.
interface prog_mem_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              load_req;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              busy;
   logic              cpu_hold;
   logic              load_ok;
   logic              load_err;

   modport master (
      output addr, load_req, ld_valid, ld_data,
      input  data, ld_ready, busy, cpu_hold, load_ok, load_err
   );

   modport slave (
      input  addr, load_req, ld_valid, ld_data,
      output data, ld_ready, busy, cpu_hold, load_ok, load_err
   );
endinterface

// File: rtl/prog_mem.sv
// Writable program memory with a streaming loader port, checksum verification
// and a CPU hold while a load session runs.
//
// state   | meaning
// S_IDLE  | no session; fetch reads memory, loader not ready
// S_LOAD  | accepting image words into mem[0..DEPTH-1]
// S_CHECK | accepting the checksum word; not stored
module prog_mem #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   prog_mem_if.slave    bus
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_sum;
   logic              r_ok;
   logic              r_err;
   logic              w_ready;
   logic              w_hs;
   logic              w_last;
   logic [DATA_W-1:0] w_sum_next;

   assign w_hs       = bus.ld_valid & w_ready;
   assign w_last     = (r_waddr == ADDR_W'(DEPTH-1));
   assign w_sum_next = r_sum + bus.ld_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // A restart request outranks any handshake in the same cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.load_req) w_next = S_LOAD;
         S_LOAD: begin
            if (bus.load_req)          w_next = S_LOAD;
            else if (w_hs && w_last)   w_next = S_CHECK;
         end
         S_CHECK: begin
            if (bus.load_req)          w_next = S_LOAD;
            else if (w_hs)             w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         S_LOAD, S_CHECK: w_ready = 1'b1;
         default:         w_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_waddr <= '0;
         r_sum   <= '0;
         r_ok    <= 1'b0;
         r_err   <= 1'b0;
      end else if (bus.load_req) begin
         r_waddr <= '0;
         r_sum   <= '0;
         r_ok    <= 1'b0;
         r_err   <= 1'b0;
      end else if (w_hs && r_state == S_LOAD) begin
         r_mem[r_waddr] <= bus.ld_data;
         r_sum          <= w_sum_next;
         if (!w_last) r_waddr <= r_waddr + 1'b1;
      end else if (w_hs && r_state == S_CHECK) begin
         r_ok  <= (w_sum_next == '0);
         r_err <= (w_sum_next != '0);
      end
   end

   assign bus.ld_ready = w_ready;
   assign bus.busy     = w_ready;
   assign bus.cpu_hold = w_ready;
   assign bus.load_ok  = r_ok;
   assign bus.load_err = r_err;
   assign bus.data     = w_ready ? '0 : r_mem[bus.addr];
endmodule

// File: doc/prog_mem.md
# prog_mem

Writable program memory for the 4-bit CPU family, parametrised in address and instruction width. It replaces the fixed instruction table, sits between the CPU fetch address and the instruction bus, and adds a valid/ready loader port. The loader port streams a full program image plus a checksum word into storage. While a load is in progress, `cpu_hold` stalls the CPU and fetch returns NOP.

## Interface
- `ADDR_W`, default 4: fetch/write address width; DEPTH = 2**ADDR_W words.
- `DATA_W`, default 8: instruction word width; also the checksum width.

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr`  in  ADDR_W  CPU fetch address.
- `data`  out  DATA_W  instruction at `addr` (combinational read).
- `load_req`  in  1  single-cycle pulse that starts or restarts a load session.
- `ld_valid`  in  1  loader word valid.
- `ld_data`  in  DATA_W  loader word.
- `ld_ready`  out  1  block accepts `ld_data` this cycle.
- `busy`  out  1  load session active (LOAD or CHECK state).
- `cpu_hold`  out  1  equals `busy`; the CPU must not advance its PC while high.
- `load_ok`  out  1  sticky; last session completed with a matching checksum.
- `load_err`  out  1  sticky; last session completed with a mismatching checksum.

## Operation
- Storage: DEPTH x DATA_W registers. All words are cleared to 0 by reset. 0 is the NOP/default encoding.
- FSM states: IDLE, LOAD, CHECK.
  - IDLE: `ld_ready`=0. `load_req`=1 moves to LOAD and, in the same edge, sets waddr=0, sum=0, clears `load_ok`/`load_err`.
  - LOAD: `ld_ready`=1.
    - Each handshake (`ld_valid`&`ld_ready`) writes mem[waddr]=`ld_data`, sets sum = (sum + `ld_data`) mod 2**DATA_W, and increments waddr.
    - The handshake that writes waddr==DEPTH-1 moves to CHECK. waddr never wraps inside a session.
  - CHECK: `ld_ready`=1. On handshake, the block computes (sum + `ld_data`) mod 2**DATA_W.
    - Result 0: set `load_ok`.
    - Otherwise: set `load_err`.
    - Return to IDLE in both cases. The checksum word is not stored.
- Restart: `load_req` in LOAD or CHECK restarts the session (waddr=0, sum=0, flags cleared, state LOAD).
  - `load_req` has priority over a same-cycle handshake; that word is discarded and not written.
  - Words already written by the aborted session remain in memory until overwritten.
- Fetch:
  - `data` = mem[`addr`] when `busy`=0.
  - `data` = 0 when `busy`=1.
- On a checksum error, memory keeps the loaded image. Software decides via `load_err`.
- `ld_valid` while `ld_ready`=0 is ignored. No write occurs and no error is raised.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE, waddr=0, sum=0.
  - all memory words 0, so `data`=0.
  - `ld_ready`=0, `busy`=0, `cpu_hold`=0, `load_ok`=0, `load_err`=0.
- `load_req` sampled high at edge N: `busy` and `ld_ready` are high after edge N. The first word can be accepted at edge N+1.
- Write latency: a word accepted at edge N is in memory after edge N. It is fetchable once `busy` drops.
- Minimum session length: DEPTH+1 handshake cycles, back-to-back with no bubbles required. Stalls (`ld_valid`=0) are allowed anywhere.
- After the CHECK handshake at edge N:
  - after edge N: `busy`=0, `cpu_hold`=0, and exactly one of `load_ok`/`load_err` is 1.
  - `data` reflects new contents in the same cycle.
- `load_ok`/`load_err` hold until the next `load_req` or reset.
- Reset mid-session: the session is aborted immediately, contents return to 0, and the flags are cleared.
- All outputs except `data` are registered or decoded from registered state. `data` is combinational from `addr`, state and memory.

## Test plan
- Reset:
  - Assert `rst_n`=0 mid-LOAD.
  - Check immediately: `busy`=0, `ld_ready`=0, flags 0, `data`=0x00 for every `addr` 0..15.
- Full good load (ADDR_W=4, DATA_W=8):
  - Stimulus: `load_req`, then 60,90,3D,01,E3,01,E1,90,9F,F7, then 6 x 00, then checksum E7.
  - Required: `load_ok`=1, `load_err`=0; `addr`=2 reads 0x3D, `addr`=9 reads 0xF7, `addr`=15 reads 0x00.
- Bad checksum:
  - Stimulus: the same image with checksum E6.
  - Required: `load_err`=1, `load_ok`=0; `addr`=0 reads 0x60 (image kept).
- Backpressure and hold:
  - Stimulus: insert random `ld_valid`=0 gaps.
  - Required: `cpu_hold`=1 and `data`=0x00 throughout the session. Exactly 17 handshakes occur. The final result matches the no-gap case.
- Restart priority:
  - Stimulus: after 5 words, assert `load_req` with `ld_valid`=1 and `ld_data`=0xAA in the same cycle.
  - Required: 0xAA is not written, waddr restarts at 0, and a subsequent full good load gives `load_ok`=1.
- Idle ignore:
  - Stimulus: `ld_valid`=1 and `ld_data`=0x55 in IDLE.
  - Required: `ld_ready`=0 and memory unchanged.
